// File: rtl/gate_vector_driver.sv
// gate_vector_driver: clocked exhaustive sweep for a combinational gate.
// Walks vec through every input combination, holds each vector for
// HOLD_CYCLES clocks and compares dut_out against TRUTH[vec] on the last
// hold cycle. It reports the mismatch count, the first failing vector and
// a pass/done flag.
//
// Start handshake: start is a level that is sampled on each rising edge.
// A start seen in IDLE or DONE launches a fresh sweep. A start seen while
// the sweep is running (DRIVE) is ignored.
module gate_vector_driver #(
  parameter int                 N_IN        = 2,
  parameter logic [2**N_IN-1:0] TRUTH       = 4'b1110,
  parameter int                 HOLD_CYCLES = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  // The hold counter only has to reach HOLD_CYCLES-1; it keeps at least one bit.
  localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic            fail_valid_q;
  logic [N_IN-1:0] fail_vec_q;

  logic            sample_edge;
  logic            mismatch;
  logic [N_IN:0]   err_d;

  // Sample-edge decode and the error count that results if this edge samples.
  always_comb begin
    sample_edge = 1'b0;
    mismatch    = 1'b0;
    err_d       = err_q;
    sample_edge = (state_q == S_DRIVE) && (cnt_q == HOLD_LAST);
    mismatch    = (dut_out != TRUTH[vec_q]);
    if (sample_edge && mismatch) begin
      err_d = err_q + {{N_IN{1'b0}}, 1'b1};
    end
  end

  // Sweep FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          vec_q <= '0;
          if (start) begin
            state_q      <= S_DRIVE;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
          end
        end
        S_DRIVE: begin
          if (sample_edge) begin
            err_q <= err_d;
            if (mismatch && !fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_vec_q   <= vec_q;
            end
            cnt_q <= '0;
            if (vec_q == VEC_LAST) begin
              // pass uses err_d so that a miss on the last vector is counted.
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
              vec_q   <= '0;
            end else begin
              vec_q <= vec_q + {{(N_IN-1){1'b0}}, 1'b1};
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_vector_driver.sv
// Directed bench for gate_vector_driver. One instance uses the default
// OR truth table with a selectable gate model. A second instance is a
// 1-input, 1-cycle-hold inverter checker.
module tb_gate_vector_driver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: defaults (OR, N_IN=2, HOLD=5) ----------------
  logic       start = 1'b0;
  logic       dut_out;
  logic [1:0] vec;
  logic       busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] fail_vec;
  int         mode = 0;  // 0 OR, 1 AND, 2 stuck1, 3 stuck0, 4 OR broken on vec 3

  gate_vector_driver dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_out    (dut_out),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

  // Gate under test model for DUT A.
  always_comb begin
    dut_out = 1'b0;
    case (mode)
      0: dut_out = vec[0] | vec[1];
      1: dut_out = vec[0] & vec[1];
      2: dut_out = 1'b1;
      3: dut_out = 1'b0;
      4: dut_out = (vec == 2'd3) ? 1'b0 : (vec[0] | vec[1]);
      default: dut_out = 1'b0;
    endcase
  end

  // ---------------- DUT B: inverter (N_IN=1, HOLD=1) ----------------
  logic       start_b = 1'b0;
  logic       dut_out_b;
  logic [0:0] vec_b;
  logic       busy_b, done_b, pass_b, fail_valid_b;
  logic [1:0] err_count_b;
  logic [0:0] fail_vec_b;

  gate_vector_driver #(
    .N_IN        (1),
    .TRUTH       (2'b01),
    .HOLD_CYCLES (1)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .dut_out    (dut_out_b),
    .vec        (vec_b),
    .busy       (busy_b),
    .done       (done_b),
    .pass       (pass_b),
    .err_count  (err_count_b),
    .fail_valid (fail_valid_b),
    .fail_vec   (fail_vec_b)
  );

  assign dut_out_b = ~vec_b[0];

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Count edges until DUT A raises done, bounded.
  task automatic wait_done_a(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  // Launch a sweep on DUT A and check the vector sequence cycle by cycle.
  // Returns the number of edges from the start edge to done.
  task automatic run_a(input bit keep_start, output int n);
    exp_q.delete();
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 5; h++)
        exp_q.push_back(4'(v));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    n = 0;
    while (!done && n < 100) begin
      if (exp_q.size() > 0) check("vec_seq", vec, exp_q.pop_front());
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("vec_queue_drained", exp_q.size(), 0);
    check("busy_at_done", busy, 0);
    check("vec_at_done", vec, 0);
  endtask

  // Directed result table: gate model -> hand-computed results for TRUTH=1110.
  int tbl_mode[5]  = '{0, 1, 2, 3, 4};
  int tbl_err[5]   = '{0, 2, 1, 3, 1};
  int tbl_fvec[5]  = '{0, 1, 0, 1, 3};
  int tbl_fv[5]    = '{0, 1, 1, 1, 1};
  int tbl_pass[5]  = '{1, 0, 0, 0, 0};

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;

    // Reset state is visible asynchronously, before any clock edge.
    #2;
    check("rst_vec", vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fail_valid", fail_valid, 0);
    check("rst_fail_vec", fail_vec, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven sweeps over several gate models.
    for (int t = 0; t < 5; t++) begin
      mode = tbl_mode[t];
      run_a(1'b0, n);
      check($sformatf("latency_m%0d", t), n, 20);
      check($sformatf("err_m%0d", t), err_count, tbl_err[t]);
      check($sformatf("fail_vec_m%0d", t), fail_vec, tbl_fvec[t]);
      check($sformatf("fail_valid_m%0d", t), fail_valid, tbl_fv[t]);
      check($sformatf("pass_m%0d", t), pass, tbl_pass[t]);
    end

    // DONE holds its results while start stays low.
    repeat (4) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_err", err_count, 1);
    check("hold_fail_vec", fail_vec, 3);
    check("hold_pass", pass, 0);

    // Asynchronous reset in the middle of a sweep (stuck-at-1 so err is nonzero first).
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_vec", vec, 1);
    check("mid_busy", busy, 1);
    check("mid_err", err_count, 1);
    check("mid_fail_valid", fail_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_vec", vec, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err_count, 0);
    check("arst_fail_valid", fail_valid, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_vec", vec, 0);
    mode = 0;
    run_a(1'b0, n);
    check("post_rst_latency", n, 20);
    check("post_rst_pass", pass, 1);
    check("post_rst_err", err_count, 0);

    // start held high through DRIVE: no restart, done at edge 20.
    mode = 0;
    run_a(1'b1, n);
    check("held_start_latency", n, 20);
    check("held_start_pass", pass, 1);
    // start still high in DONE: restart on the next edge.
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    check("restart_vec", vec, 0);
    check("restart_pass", pass, 0);
    wait_done_a(n);
    check("restart_latency", n, 20);
    check("restart_final_pass", pass, 1);

    // Inverter checker: N_IN=1, HOLD=1, done at edge 2.
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    check("inv_busy", busy_b, 1);
    check("inv_vec0", vec_b, 0);
    n = 0;
    while (!done_b && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) check("inv_vec1", vec_b, 1);
    end
    check("inv_latency", n, 2);
    check("inv_pass", pass_b, 1);
    check("inv_err", err_count_b, 0);
    check("inv_fail_valid", fail_valid_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
